// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and frame geometry.
// Also imported by the UART receiver, so keep changes backward compatible.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// While clr is high the count is held at zero so the next bit starts aligned.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  assign tick = !clr && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining 8N1 UART transmitter: pops one byte from a registered-read FIFO
// whenever idle and enabled, then shifts it out LSB first on a registered tx line.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done,
  output logic [2:0] state_dbg
);

  // Handshake: fifo_rd_en is a single-cycle pop request raised only in IDLE when
  // tx_en is high and fifo_empty is low; the FIFO presents the popped byte on
  // fifo_data in the following cycle (FETCH), where it is captured. No other
  // FIFO signal is looked at outside IDLE.

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 baud_clr;
  logic                 tick;

  // Bit timing only runs once a frame is on the line; IDLE and FETCH hold it cleared.
  assign baud_clr = (state_q == ST_IDLE) || (state_q == ST_FETCH);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (baud_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    fifo_rd_en = 1'b0;
    tx_done    = 1'b0;
    tx_d       = 1'b1;

    case (state_q)
      ST_IDLE: begin
        fifo_rd_en = tx_en & ~fifo_empty;
        if (tx_en & ~fifo_empty) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        shreg_d = fifo_data;
        state_d = ST_START;
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          tx_done = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The line level is chosen from the state being entered, so tx is already
    // correct in the first cycle of every bit despite being registered.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx        = tx_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule
